// File: rtl/filtr_driver.sv
// ---------------------------------------------------------------------------
// filtr_driver
//
// Sample sequencer for the adaptive notch filter core. It sits between the
// ADC deserializer and the filter. Samples arrive on a valid/ready stream and
// are buffered in a small FIFO. Each sample gets one five-cycle filter
// transaction: a single-cycle trigger, then a wait for the filter's done
// strobe, then capture of the result. The result leaves on a second
// valid/ready stream.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   s_data/s_valid/s_ready   input sample stream (s_ready = FIFO not full)
//   m_data/m_valid/m_ready   filter result stream
//   coef_in/coef_wr     new coefficient, written into a shadow register
//   flt_data_in, flt_a  sample and coefficient driven to the filter, held
//                       stable for the whole transaction
//   flt_trig            one-cycle start strobe to the filter
//   flt_done            filter completion strobe
//   flt_data_out        filter output register
//   busy                a transaction is in progress
//   err                 sticky timeout flag
//
// Build option:
//   FILTR_DRV_TIMEOUT_EN  when defined, a transaction whose done strobe does
//                         not arrive within TIMEOUT cycles of waiting is
//                         abandoned and err is set. When undefined, WAIT
//                         waits forever and err is tied low.
// ---------------------------------------------------------------------------
module filtr_driver #(
  parameter int DATA_SIZE  = 24,
  parameter int COEF_SIZE  = 35,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  input  logic [COEF_SIZE-1:0] coef_in,
  input  logic                 coef_wr,
  output logic [DATA_SIZE-1:0] flt_data_in,
  output logic [COEF_SIZE-1:0] flt_a,
  output logic                 flt_trig,
  input  logic                 flt_done,
  input  logic [DATA_SIZE-1:0] flt_data_out,
  output logic                 busy,
  output logic                 err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT,
    CAPT,
    HOLD
  } state_t;

  state_t state, state_next;

  logic [DATA_SIZE-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       fifo_cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_wr;
  logic                 fifo_rd;
  logic                 ready_en;
  logic [COEF_SIZE-1:0] coef_shadow;
  logic                 hold_last;
  logic                 launch;
  logic                 timeout_hit;

  // ---------------------------------------------------------------------------
  // Input FIFO. s_ready is the only write gate, so a write can never land on
  // a full FIFO. ready_en keeps s_ready low while reset is asserted and lets
  // it rise on the first clock after release.
  // ---------------------------------------------------------------------------
  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign s_ready    = ready_en & ~fifo_full;
  assign fifo_wr    = s_valid & s_ready;
  assign fifo_rd    = launch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      ready_en <= 1'b1;
      if (fifo_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd)
        rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (fifo_wr)
      fifo_mem[wr_ptr] <= s_data;
  end

  // ---------------------------------------------------------------------------
  // Launch decision. The second HOLD cycle doubles as the IDLE decision so a
  // continuously fed stream triggers every five cycles rather than six. A new
  // transaction never starts while an unaccepted result is still on m_data.
  // ---------------------------------------------------------------------------
  assign launch = ((state == IDLE) || ((state == HOLD) && hold_last)) &&
                  !fifo_empty && (!m_valid || m_ready);

  // ---------------------------------------------------------------------------
  // Optional done-strobe watchdog. The counter is cleared in TRIG and counts
  // WAIT cycles; the hit fires on the last allowed WAIT cycle without done.
  // ---------------------------------------------------------------------------
`ifdef FILTR_DRV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign timeout_hit = (state == WAIT) && !flt_done &&
                       (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign err         = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == TRIG)
        tmo_cnt <= '0;
      else if (state == WAIT)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (timeout_hit)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register plus the HOLD cycle counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold_last <= 1'b0;
    end else begin
      state     <= state_next;
      hold_last <= (state == HOLD) ? !hold_last : 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (launch) state_next = TRIG;
      TRIG: state_next = WAIT;
      WAIT: begin
        if (flt_done)
          state_next = CAPT;
        else if (timeout_hit)
          state_next = HOLD;
      end
      CAPT: state_next = HOLD;
      HOLD: begin
        if (hold_last)
          state_next = launch ? TRIG : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    flt_trig = (state == TRIG);
    busy     = (state != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. The filter operands only change on a launch, so they
  // stay frozen from the trigger through the last HOLD cycle. In the output
  // stream a capture wins over a same-cycle acceptance.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_shadow <= '0;
      flt_data_in <= '0;
      flt_a       <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
    end else begin
      if (coef_wr)
        coef_shadow <= coef_in;
      if (launch) begin
        flt_data_in <= fifo_mem[rd_ptr];
        flt_a       <= coef_shadow;
      end
      if (state == CAPT) begin
        m_data  <= flt_data_out;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_filtr_driver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_filtr_driver
//
// Directed bench for filtr_driver with a scoreboard. applyStimulus pushes the
// expected trigger operands and filter result for every accepted sample; a
// negedge monitor pops and compares on each trigger and each output
// handshake. A stub filter answers a trigger with done one cycle later and
// returns flt_data_in + 1.
// ---------------------------------------------------------------------------
module tb_filtr_driver;

  localparam int DATA_SIZE  = 24;
  localparam int COEF_SIZE  = 35;
  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 16;
  localparam logic [COEF_SIZE-1:0] COEF_A1 = 35'h1_0000_0000;
  localparam logic [COEF_SIZE-1:0] COEF_A7 = 35'd7;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [DATA_SIZE-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [COEF_SIZE-1:0] coef_in;
  logic                 coef_wr;
  logic [DATA_SIZE-1:0] flt_data_in;
  logic [COEF_SIZE-1:0] flt_a;
  logic                 flt_trig;
  logic                 flt_done;
  logic [DATA_SIZE-1:0] flt_data_out;
  logic                 busy;
  logic                 err;

  logic                 stub_mute;
  int                   cyc = 0;
  int                   tests = 0;
  int                   fails = 0;
  int                   accept_cyc;
  int                   last_trig_cyc;
  int                   trig_count = 0;
  bit                   cadence_en;

  logic [DATA_SIZE-1:0] trig_d_q [$];
  logic [COEF_SIZE-1:0] trig_a_q [$];
  logic [DATA_SIZE-1:0] out_q [$];
  logic [DATA_SIZE-1:0] ref_d;
  logic [COEF_SIZE-1:0] ref_a;
  logic [DATA_SIZE-1:0] mon_d;
  logic [COEF_SIZE-1:0] mon_a;

  filtr_driver #(
    .DATA_SIZE (DATA_SIZE),
    .COEF_SIZE (COEF_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .coef_in     (coef_in),
    .coef_wr     (coef_wr),
    .flt_data_in (flt_data_in),
    .flt_a       (flt_a),
    .flt_trig    (flt_trig),
    .flt_done    (flt_done),
    .flt_data_out(flt_data_out),
    .busy        (busy),
    .err         (err)
  );

  // 10 MHz system clock.
  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub filter: done one cycle after the trigger, result = sample + 1.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      flt_done     <= 1'b0;
      flt_data_out <= '0;
    end else begin
      flt_done <= flt_trig && !stub_mute;
      if (flt_trig)
        flt_data_out <= flt_data_in + DATA_SIZE'(1);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flagFail(input string name, input string what);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got %s", name, what);
  endtask

  // Offer one sample and record the expected trigger operands and result.
  task automatic applyStimulus(input logic [DATA_SIZE-1:0] d,
                               input logic [COEF_SIZE-1:0] a,
                               input bit expect_out);
    int  n = 0;
    bit  took = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!took && n < 200) begin
      @(negedge clk);
      if (s_ready) took = 1;
      else n++;
    end
    if (took) begin
      accept_cyc = cyc;
      trig_d_q.push_back(d);
      trig_a_q.push_back(a);
      if (expect_out)
        out_q.push_back(d + DATA_SIZE'(1));
    end else begin
      flagFail("accept_timeout", "s_ready never rose, required acceptance");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic waitTrig(input int budget, output int tcyc);
    int n = 0;
    tcyc = -1;
    while (tcyc < 0 && n < budget) begin
      @(negedge clk);
      if (flt_trig) tcyc = cyc;
      n++;
    end
    if (tcyc < 0)
      flagFail("trig_timeout", "no flt_trig, required one");
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((out_q.size() != 0 || trig_d_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget)
      flagFail("drain_timeout", "pending transactions, required none");
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (flt_trig) begin
        if (trig_d_q.size() == 0) begin
          flagFail("unexpected_trig", "flt_trig with nothing queued, required none");
        end else begin
          mon_d = trig_d_q.pop_front();
          mon_a = trig_a_q.pop_front();
          checkOutput("trig_data", 64'(flt_data_in), 64'(mon_d));
          checkOutput("trig_coef", 64'(flt_a), 64'(mon_a));
        end
        if (last_trig_cyc >= 0) begin
          if (cadence_en)
            checkOutput("trig_cadence", 64'(cyc - last_trig_cyc), 64'd5);
          else
            checkOutput("trig_spacing_min", 64'(cyc - last_trig_cyc >= 5), 64'd1);
        end
        last_trig_cyc = cyc;
        ref_d = flt_data_in;
        ref_a = flt_a;
        trig_count++;
      end else if (busy) begin
        checkOutput("flt_data_in_stable", 64'(flt_data_in), 64'(ref_d));
        checkOutput("flt_a_stable", 64'(flt_a), 64'(ref_a));
      end
      if (m_valid && m_ready) begin
        if (out_q.size() == 0) begin
          flagFail("unexpected_out", "m_valid with nothing expected, required none");
        end else begin
          mon_d = out_q.pop_front();
          checkOutput("m_data", 64'(m_data), 64'(mon_d));
        end
      end
    end
  end

  initial begin
    int t;
    int t2;
    int tc;
    int n;
    int rel;

    reset         = 1'b1;
    s_valid       = 1'b0;
    s_data        = '0;
    m_ready       = 1'b1;
    coef_in       = '0;
    coef_wr       = 1'b0;
    stub_mute     = 1'b0;
    cadence_en    = 1'b0;
    last_trig_cyc = -1;
    accept_cyc    = 0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_m_data", 64'(m_data), 64'd0);
    checkOutput("rst_flt_data_in", 64'(flt_data_in), 64'd0);
    checkOutput("rst_flt_a", 64'(flt_a), 64'd0);
    checkOutput("rst_flt_trig", 64'(flt_trig), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("s_ready_after_rst", 64'(s_ready), 64'd1);

    // Single sample: latency and coefficient pickup.
    coef_in = COEF_A1;
    coef_wr = 1'b1;
    @(posedge clk);
    #1;
    coef_wr = 1'b0;
    applyStimulus(24'd100, COEF_A1, 1'b1);
    waitTrig(20, t);
    checkOutput("trig_latency", 64'(t - accept_cyc), 64'd2);
    checkOutput("first_flt_a", 64'(flt_a), 64'(COEF_A1));
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("m_valid_latency", 64'(cyc - accept_cyc), 64'd5);
    checkOutput("first_m_data", 64'(m_data), 64'd101);
    drain(100);

    // Burst 1..8 with a free output: triggers every five cycles.
    cadence_en    = 1'b1;
    last_trig_cyc = -1;
    for (int i = 1; i <= 8; i++)
      applyStimulus(DATA_SIZE'(i), COEF_A1, 1'b1);
    drain(200);
    cadence_en = 1'b0;

    // Output held: FIFO fills, result stays put, no new trigger.
    m_ready = 1'b0;
    for (int i = 10; i <= 18; i++)
      applyStimulus(DATA_SIZE'(i), COEF_A1, 1'b1);
    checkOutput("s_ready_full", 64'(s_ready), 64'd0);
    tc = trig_count;
    repeat (10) @(negedge clk);
    checkOutput("hold_m_valid", 64'(m_valid), 64'd1);
    checkOutput("hold_m_data", 64'(m_data), 64'd11);
    checkOutput("hold_no_trig", 64'(trig_count), 64'(tc));
    checkOutput("hold_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    rel = cyc;
    waitTrig(5, t);
    checkOutput("trig_after_release", 64'(t - rel), 64'd1);
    drain(200);

    // Coefficient written mid-transaction takes effect on the next trigger.
    applyStimulus(24'd30, COEF_A1, 1'b1);
    applyStimulus(24'd31, COEF_A7, 1'b1);
    waitTrig(10, t);
    repeat (2) @(posedge clk);
    #1;
    coef_in = COEF_A7;
    coef_wr = 1'b1;
    @(posedge clk);
    #1;
    coef_wr = 1'b0;
    @(negedge clk);
    checkOutput("flt_a_kept_t3", 64'(flt_a), 64'(COEF_A1));
    waitTrig(10, t2);
    checkOutput("coef_next_trig_cycle", 64'(t2 - t), 64'd5);
    checkOutput("coef_next_flt_a", 64'(flt_a), 64'(COEF_A7));
    drain(100);

    // Reset at t+3 with three samples queued.
    applyStimulus(24'd20, COEF_A7, 1'b1);
    applyStimulus(24'd21, COEF_A7, 1'b1);
    applyStimulus(24'd22, COEF_A7, 1'b1);
    applyStimulus(24'd23, COEF_A7, 1'b1);
    n = 0;
    while (cyc < last_trig_cyc + 3 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    reset = 1'b1;
    trig_d_q.delete();
    trig_a_q.delete();
    out_q.delete();
    #1;
    checkOutput("midrst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("midrst_m_data", 64'(m_data), 64'd0);
    checkOutput("midrst_flt_data_in", 64'(flt_data_in), 64'd0);
    checkOutput("midrst_flt_a", 64'(flt_a), 64'd0);
    checkOutput("midrst_flt_trig", 64'(flt_trig), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_s_ready", 64'(s_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset         = 1'b0;
    last_trig_cyc = -1;
    tc            = trig_count;
    repeat (12) @(negedge clk);
    checkOutput("postrst_no_trig", 64'(trig_count), 64'(tc));
    checkOutput("postrst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("postrst_s_ready", 64'(s_ready), 64'd1);
    checkOutput("postrst_busy", 64'(busy), 64'd0);

`ifdef FILTR_DRV_TIMEOUT_EN
    // Missing done strobe: err after TIMEOUT WAIT cycles, sample dropped.
    stub_mute = 1'b1;
    applyStimulus(24'd50, '0, 1'b0);
    waitTrig(10, t);
    applyStimulus(24'd60, '0, 1'b1);
    while (cyc < t + TIMEOUT) @(negedge clk);
    checkOutput("err_before_timeout", 64'(err), 64'd0);
    @(negedge clk);
    checkOutput("err_at_timeout", 64'(err), 64'd1);
    checkOutput("timeout_no_m_valid", 64'(m_valid), 64'd0);
    stub_mute = 1'b0;
    waitTrig(10, t2);
    checkOutput("trig_after_timeout", 64'(t2 - t), 64'(TIMEOUT + 3));
    drain(100);
    checkOutput("err_sticky", 64'(err), 64'd1);
`else
    checkOutput("err_tied_low", 64'(err), 64'd0);
`endif

    if (out_q.size() != 0 || trig_d_q.size() != 0)
      flagFail("scoreboard_leftover", "expected entries never seen, required empty");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #5ms;
    $display("[TB] FAIL global_timeout: got no finish, required finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

endmodule
